// File: rtl/pipeline_control_if.sv
// Decode/EX handshake bundle between the instruction pipeline and its control block.
// The master side is the pipeline datapath; the slave side is pipeline_control.
interface pipeline_control_if;
  logic       dec_valid;
  logic       dec_use_ra;
  logic       dec_use_rt;
  logic [3:0] dec_rt_addr;
  logic       dec_use_rw;
  logic [3:0] dec_rw_addr;
  logic       dec_read_ps;
  logic       dec_write_ps;
  logic       dec_jump;
  logic       dec_branch;
  logic       dec_interrupt;
  logic       dec_halt;
  logic       br_resolve;
  logic       br_taken;
  logic       resume;
  logic       int_ack;
  logic       dec_ready;
  logic       issue;
  logic       fetch_en;
  logic       flush;
  logic       halted;
  logic       int_req;

  modport master (
    output dec_valid, dec_use_ra, dec_use_rt, dec_rt_addr, dec_use_rw, dec_rw_addr,
           dec_read_ps, dec_write_ps, dec_jump, dec_branch, dec_interrupt, dec_halt,
           br_resolve, br_taken, resume, int_ack,
    input  dec_ready, issue, fetch_en, flush, halted, int_req
  );

  modport slave (
    input  dec_valid, dec_use_ra, dec_use_rt, dec_rt_addr, dec_use_rw, dec_rw_addr,
           dec_read_ps, dec_write_ps, dec_jump, dec_branch, dec_interrupt, dec_halt,
           br_resolve, br_taken, resume, int_ack,
    output dec_ready, issue, fetch_en, flush, halted, int_req
  );
endinterface

// File: rtl/pipeline_control.sv
// In-order issue control: two-slot write scoreboard for RAW stalls, branch wait,
// halt/interrupt drain, and restart flush generation.
module pipeline_control (
  input  logic               clk,
  input  logic               rst,
  pipeline_control_if.slave  bus
);

  localparam int unsigned ADDR_W = 4;

  typedef enum logic [2:0] {
    S_RUN,
    S_WAIT_BR,
    S_DRAIN_HLT,
    S_DRAIN_INT,
    S_HALTED,
    S_INT
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              wr_reg;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_ps;
  } slot_t;

  state_t state_q, state_d;
  slot_t  ex_q, wb_q, ex_d;
  logic   hazard_c;
  logic   dec_ready_c, issue_c, flush_c;
  logic   fetch_en_q, halted_q, int_req_q;

  // A slot conflicts with the decode instruction if it will write something decode reads.
  function automatic logic slot_hit(
    input slot_t             s,
    input logic              use_ra,
    input logic              use_rt,
    input logic [ADDR_W-1:0] rt_addr,
    input logic              read_ps
  );
    return s.valid && ((use_ra && s.wr_reg && (s.wr_addr == ADDR_W'(0))) ||
                       (use_rt && s.wr_reg && (s.wr_addr == rt_addr)) ||
                       (read_ps && s.wr_ps));
  endfunction

  assign hazard_c = slot_hit(ex_q, bus.dec_use_ra, bus.dec_use_rt, bus.dec_rt_addr, bus.dec_read_ps) |
                    slot_hit(wb_q, bus.dec_use_ra, bus.dec_use_rt, bus.dec_rt_addr, bus.dec_read_ps);

  // Next state and the combinational handshake outputs.
  always_comb begin
    state_d     = state_q;
    dec_ready_c = 1'b0;
    issue_c     = 1'b0;
    flush_c     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_RUN: begin
          if (bus.dec_valid && !hazard_c) begin
            dec_ready_c = 1'b1;
            if (bus.dec_halt) begin
              state_d = S_DRAIN_HLT;
            end else if (bus.dec_interrupt) begin
              state_d = S_DRAIN_INT;
            end else begin
              issue_c = 1'b1;
              if (bus.dec_jump || bus.dec_branch) begin
                state_d = S_WAIT_BR;
              end
            end
          end
        end
        S_WAIT_BR: begin
          if (bus.br_resolve) begin
            state_d = S_RUN;
            flush_c = bus.br_taken;
          end
        end
        // WB retires this cycle, so an empty EX slot means nothing is left in flight.
        S_DRAIN_HLT: begin
          if (!ex_q.valid) begin
            state_d = S_HALTED;
          end
        end
        S_DRAIN_INT: begin
          if (!ex_q.valid) begin
            state_d = S_INT;
          end
        end
        S_HALTED: begin
          if (bus.resume) begin
            state_d = S_RUN;
            flush_c = 1'b1;
          end
        end
        S_INT: begin
          if (bus.int_ack) begin
            state_d = S_RUN;
            flush_c = 1'b1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Entry loaded into the EX slot for the instruction issued this cycle.
  always_comb begin
    ex_d = '0;
    if (issue_c) begin
      ex_d.valid   = 1'b1;
      ex_d.wr_reg  = bus.dec_use_rw;
      ex_d.wr_addr = bus.dec_rw_addr;
      ex_d.wr_ps   = bus.dec_write_ps;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      ex_q       <= '0;
      wb_q       <= '0;
      fetch_en_q <= 1'b1;
      halted_q   <= 1'b0;
      int_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_q       <= ex_d;
      wb_q       <= ex_q;
      fetch_en_q <= (state_d == S_RUN);
      halted_q   <= (state_d == S_HALTED);
      int_req_q  <= (state_d == S_INT);
    end
  end

  assign bus.dec_ready = dec_ready_c;
  assign bus.issue     = issue_c;
  assign bus.flush     = flush_c;
  assign bus.fetch_en  = fetch_en_q;
  assign bus.halted    = halted_q;
  assign bus.int_req   = int_req_q;

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decode slot holds an instruction
- dec_use_ra  in  1  instruction reads ra (register r0)
- dec_use_rt  in  1  instruction reads register rt
- dec_rt_addr  in  4  rt register address
- dec_use_rw  in  1  instruction writes a register
- dec_rw_addr  in  4  destination register address
- dec_read_ps  in  1  instruction reads the predicate/status bit
- dec_write_ps  in  1  instruction writes the predicate/status bit
- dec_jump, dec_branch  in  1 each  control-transfer instruction
- dec_interrupt, dec_halt  in  1 each  INT / HLT instruction
- br_resolve  in  1  EX-stage pulse: the outstanding jump/branch has resolved
- br_taken  in  1  qualifies br_resolve; control transfer taken
- resume  in  1  external restart from halt
- int_ack  in  1  interrupt handler accepted the request
- dec_ready  out  1  decode instruction consumed this cycle
- issue  out  1  instruction sent to EX this cycle
- fetch_en  out  1  fetch may advance
- flush  out  1  discard fetch/decode contents
- halted  out  1  core is halted
- int_req  out  1  interrupt request to handler
REQ-002 Clock and reset SHALL be exactly as stated: one clock, clk; reset rst is synchronous and active-high.

Function
REQ-003 SHALL hold a 2-entry in-flight scoreboard (EX, WB slots); each slot holds valid, wr_reg, wr_addr[3:0] and wr_ps.
REQ-004 Every cycle SHALL shift EX into WB; EX loads {1, dec_use_rw, dec_rw_addr, dec_write_ps} when issue=1, otherwise EX.valid=0.
REQ-005 A hazard SHALL exist when any valid slot matches: (dec_use_ra and wr_reg and wr_addr=0), (dec_use_rt and wr_reg and wr_addr=dec_rt_addr) or (dec_read_ps and wr_ps). No forwarding; maximum stall is 2 cycles.
REQ-006 SHALL implement states RUN, WAIT_BR, DRAIN_HLT, DRAIN_INT, HALTED, INT.
REQ-007 In RUN with dec_valid=1 and no hazard:
- HLT: dec_ready=1, issue=0, go to DRAIN_HLT.
- INT: dec_ready=1, issue=0, go to DRAIN_INT.
- Otherwise: dec_ready=1, issue=1; if jump or branch, go to WAIT_BR.
REQ-008 issue, dec_ready and flush SHALL be combinational from the current state and inputs; all other outputs SHALL be registered state decodes.
REQ-009 fetch_en SHALL be 1 only in RUN; a stall holds fetch via dec_ready=0 and does not clear fetch_en.
REQ-010 WAIT_BR: dec_ready=0, issue=0, fetch_en=0. On br_resolve go to RUN next cycle; in that cycle flush=br_taken. br_resolve in any other state SHALL be ignored.
REQ-011 DRAIN_HLT/DRAIN_INT: fetch_en=0, no issue. Once both slots are invalid, go to HALTED or INT respectively.
REQ-012 HALTED: halted=1. On resume go to RUN with flush=1 for that cycle. resume in any other state SHALL be ignored.
REQ-013 INT: int_req=1. On int_ack go to RUN with flush=1 for that cycle. int_ack elsewhere SHALL be ignored; int_req SHALL hold until int_ack.
REQ-014 When dec_valid=0, dec_ready=0 and issue=0, and no state change occurs from RUN.
REQ-015 An instruction with both jump and branch set SHALL be treated as one control transfer.

Reset
REQ-016 When rst=1 at a clock edge: state=RUN, both slots invalid, fetch_en=1, halted=0, int_req=0.
REQ-017 While rst=1, dec_ready, issue and flush SHALL be 0.
REQ-018 Reset mid-operation (any state, including WAIT_BR or INT) SHALL abandon the operation without flush or int_req glitch.

Verification
REQ-019 SHALL cover these directed scenarios:
- NND writing r0, then LS using ra: second instruction stalls 2 cycles (dec_ready=0), then issue=1.
- EQ (write_ps) then BR (read_ps): BR stalls 2 cycles, issues, enters WAIT_BR; br_resolve=1, br_taken=1 after 3 cycles -> flush=1 for one cycle, fetch_en=1 next cycle.
- CP r5 then NND rt=5 and CP r5 then NND rt=6: stall of 2 cycles for rt=5, no stall for rt=6.
- HLT with two instructions in flight: halted=1 exactly 2 cycles after dec_ready; resume -> flush=1, then RUN.
- INT: int_req held 10 cycles with no ack, resume pulses ignored; int_ack -> int_req=0 and flush=1.
- rst asserted in WAIT_BR and INT: next cycle fetch_en=1, int_req=0, scoreboard empty (no stall on next instruction).
